fifo_drain: RTL and testbench

Downstream consumer for the nibble-packing flush FIFO. It pops 32-bit rows from the FIFO whenever data is available and it has space. It serializes each row into four bytes, least significant first, on a valid/ready stream. It also sequences a FIFO flush on request and marks the final byte of the flushed data with `out_last_o`.

---
 rtl/fifo_drain.sv | 132 +++++++++++++
 tb/tb_fifo_drain.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_drain.sv
// rtl/fifo_drain.sv - pops 32-bit FIFO rows and serializes them LSB-byte-first with flush sequencing
//
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   fifo_data_avail_i     FIFO has a readable row
//   fifo_rd_data_i        row at FIFO read pointer (valid with fifo_rd_valid_o)
//   fifo_empty_i          FIFO holds no nibbles (only used at flush request)
//   fifo_flush_done_i     high in the cycle the final flushed row is read
//   fifo_rd_valid_o       pop strobe, one row per high cycle
//   fifo_flush_o          flush request to the FIFO, held until flush done pop
//   flush_req_i           single-cycle flush command
//   flush_busy_o          flush sequence in progress
//   flush_done_o          one-cycle pulse on flush completion
//   out_valid_o/out_data_o/out_last_o/out_ready_i   byte stream
module fifo_drain (
    input  logic        clk,
    input  logic        reset,
    input  logic        fifo_data_avail_i,
    input  logic [31:0] fifo_rd_data_i,
    input  logic        fifo_empty_i,
    input  logic        fifo_flush_done_i,
    output logic        fifo_rd_valid_o,
    output logic        fifo_flush_o,
    input  logic        flush_req_i,
    output logic        flush_busy_o,
    output logic        flush_done_o,
    output logic        out_valid_o,
    output logic [7:0]  out_data_o,
    output logic        out_last_o,
    input  logic        out_ready_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] hold_q, hold_d;
    logic        hold_vld_q, hold_vld_d;
    logic        hold_last_q, hold_last_d;
    logic [1:0]  idx_q, idx_d;
    logic        flush_done_q, flush_done_d;

    logic        drain_wait;
    logic        accept;
    logic        pop;
    logic        last_byte;

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        hold_vld_d   = hold_vld_q;
        hold_last_d  = hold_last_q;
        idx_d        = idx_q;
        flush_done_d = 1'b0;

        // Once the final flushed row is held, stop popping so that nothing
        // written after the flush can overtake the flagged last byte.
        drain_wait = (state_q == DRAIN);
        accept     = hold_vld_q & out_ready_i;
        last_byte  = hold_vld_q & hold_last_q & (idx_q == 2'd3);
        // A pop may coincide with acceptance of byte 3, giving zero bubble.
        pop        = fifo_data_avail_i & ~reset & ~drain_wait &
                     (~hold_vld_q | ((idx_q == 2'd3) & out_ready_i));

        if (pop) begin
            hold_d      = fifo_rd_data_i;
            hold_vld_d  = 1'b1;
            hold_last_d = (state_q == FLUSH) & fifo_flush_done_i;
            idx_d       = 2'd0;
        end else if (accept) begin
            idx_d = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
                hold_vld_d = 1'b0;
            end
        end

        case (state_q)
            IDLE: begin
                if (flush_req_i) begin
                    // Nothing buffered anywhere: complete without bothering the FIFO.
                    if (fifo_empty_i & ~hold_vld_q) begin
                        flush_done_d = 1'b1;
                    end else begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (pop & fifo_flush_done_i) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (last_byte & out_ready_i) begin
                    state_d      = IDLE;
                    flush_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            hold_q       <= 32'd0;
            hold_vld_q   <= 1'b0;
            hold_last_q  <= 1'b0;
            idx_q        <= 2'd0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            hold_vld_q   <= hold_vld_d;
            hold_last_q  <= hold_last_d;
            idx_q        <= idx_d;
            flush_done_q <= flush_done_d;
        end
    end

    assign fifo_rd_valid_o = pop;
    assign fifo_flush_o    = (state_q == FLUSH);
    assign flush_busy_o    = (state_q != IDLE);
    assign flush_done_o    = flush_done_q;
    assign out_valid_o     = hold_vld_q;
    assign out_data_o      = hold_q[{idx_q, 3'b000} +: 8];
    assign out_last_o      = last_byte;

endmodule

// File: tb/tb_fifo_drain.sv
// tb/tb_fifo_drain.sv - scoreboard bench for fifo_drain
module tb_fifo_drain;

    logic        clk;
    logic        reset;
    logic        fifo_data_avail_i;
    logic [31:0] fifo_rd_data_i;
    logic        fifo_empty_i;
    logic        fifo_flush_done_i;
    logic        fifo_rd_valid_o;
    logic        fifo_flush_o;
    logic        flush_req_i;
    logic        flush_busy_o;
    logic        flush_done_o;
    logic        out_valid_o;
    logic [7:0]  out_data_o;
    logic        out_last_o;
    logic        out_ready_i;

    fifo_drain dut (
        .clk               (clk),
        .reset             (reset),
        .fifo_data_avail_i (fifo_data_avail_i),
        .fifo_rd_data_i    (fifo_rd_data_i),
        .fifo_empty_i      (fifo_empty_i),
        .fifo_flush_done_i (fifo_flush_done_i),
        .fifo_rd_valid_o   (fifo_rd_valid_o),
        .fifo_flush_o      (fifo_flush_o),
        .flush_req_i       (flush_req_i),
        .flush_busy_o      (flush_busy_o),
        .flush_done_o      (flush_done_o),
        .out_valid_o       (out_valid_o),
        .out_data_o        (out_data_o),
        .out_last_o        (out_last_o),
        .out_ready_i       (out_ready_i)
    );

    typedef struct {
        logic [31:0] d;
        logic        done;
    } row_t;

    typedef struct {
        logic [7:0] b;
        logic       last;
    } exp_t;

    row_t rows[$];
    exp_t sb[$];
    int   pop_cyc[$];
    int   acc_cyc[$];

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   last_seen = 0;
    bit   pop_seen = 0;
    bit   partial = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model: inputs updated a little after each edge, after a seen pop.
    always @(posedge clk) begin
        #2;
        if (pop_seen && rows.size() != 0) void'(rows.pop_front());
        pop_seen = 0;
        fifo_data_avail_i = (rows.size() != 0);
        fifo_rd_data_i    = (rows.size() != 0) ? rows[0].d : 32'h0;
        fifo_flush_done_i = (rows.size() != 0) ? rows[0].done : 1'b0;
        fifo_empty_i      = (rows.size() == 0) && !partial;
    end

    // Scoreboard: compare accepted bytes, then expand any popped row.
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid_o && out_ready_i) begin
                exp_t e;
                acc_cyc.push_back(cyc);
                if (out_last_o) last_seen++;
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected_byte got=%02h last=%0b expected none", out_data_o, out_last_o);
                end else begin
                    e = sb.pop_front();
                    if (out_data_o !== e.b || out_last_o !== e.last) begin
                        failures++;
                        $display("FAIL sb_byte got=%02h/%0b expected=%02h/%0b", out_data_o, out_last_o, e.b, e.last);
                    end
                end
            end
            if (fifo_rd_valid_o) begin
                pop_seen = 1;
                pop_cyc.push_back(cyc);
                for (int i = 0; i < 4; i++) begin
                    exp_t n;
                    n.b    = fifo_rd_data_i[i*8 +: 8];
                    n.last = (i == 3) && fifo_flush_done_i;
                    sb.push_back(n);
                end
            end
        end
    end

    task automatic wait_drain(output bit ok);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rows.size() == 0 && sb.size() == 0 && !out_valid_o && !flush_busy_o) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        row_t r;
        bit ok;
        @(posedge clk); #1;
        reset = 1;
        out_ready_i = 1;
        r.d = 32'h87654321; r.done = 0;
        rows.push_back(r);
        pop_cyc.delete(); acc_cyc.delete();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (fifo_rd_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL rd_valid_in_reset got=%0b expected=0", fifo_rd_valid_o);
        end
        @(posedge clk); #1;
        reset = 0;
        @(negedge clk);
        checks++;
        if ({out_valid_o, out_data_o, out_last_o, fifo_flush_o, flush_busy_o, flush_done_o} !== 13'd0) begin
            failures++;
            $display("FAIL reset_outputs got v=%0b d=%02h l=%0b fl=%0b b=%0b dn=%0b expected all 0",
                     out_valid_o, out_data_o, out_last_o, fifo_flush_o, flush_busy_o, flush_done_o);
        end
        wait_drain(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL single_drain timeout"); end
        checks++;
        if (pop_cyc.size() != 1 || acc_cyc.size() != 4) begin
            failures++;
            $display("FAIL single_counts pops=%0d bytes=%0d expected 1/4", pop_cyc.size(), acc_cyc.size());
        end else begin
            checks++;
            if (acc_cyc[0] != pop_cyc[0] + 1 || acc_cyc[3] != acc_cyc[0] + 3) begin
                failures++;
                $display("FAIL single_timing pop=%0d first=%0d last=%0d expected first=pop+1 last=first+3",
                         pop_cyc[0], acc_cyc[0], acc_cyc[3]);
            end
        end
    endtask

    task automatic test_back_to_back;
        row_t r;
        bit ok;
        @(posedge clk); #1;
        pop_cyc.delete(); acc_cyc.delete();
        out_ready_i = 1;
        r.done = 0;
        r.d = 32'h11111111; rows.push_back(r);
        r.d = 32'h22222222; rows.push_back(r);
        wait_drain(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL b2b_drain timeout"); end
        checks++;
        if (pop_cyc.size() != 2 || acc_cyc.size() != 8) begin
            failures++;
            $display("FAIL b2b_counts pops=%0d bytes=%0d expected 2/8", pop_cyc.size(), acc_cyc.size());
        end else begin
            checks++;
            if (pop_cyc[1] - pop_cyc[0] != 4) begin
                failures++;
                $display("FAIL b2b_pop_gap got=%0d expected=4", pop_cyc[1] - pop_cyc[0]);
            end
            checks++;
            if (acc_cyc[7] - acc_cyc[0] != 7) begin
                failures++;
                $display("FAIL b2b_bubble span=%0d expected=7", acc_cyc[7] - acc_cyc[0]);
            end
        end
    endtask

    task automatic test_stall;
        row_t r;
        bit ok;
        bit got;
        int npops;
        @(posedge clk); #1;
        pop_cyc.delete(); acc_cyc.delete();
        out_ready_i = 1;
        r.done = 0;
        r.d = 32'hA1B2C3D4; rows.push_back(r);
        r.d = 32'h0F1E2D3C; rows.push_back(r);
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (fifo_rd_valid_o) begin got = 1; break; end
        end
        checks++;
        if (!got) begin failures++; $display("FAIL stall_first_pop timeout"); end
        @(posedge clk); #1;          // byte 0 presented, ready=1
        @(posedge clk); #1;          // byte 1 presented
        out_ready_i = 0;
        npops = pop_cyc.size();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (out_data_o !== 8'hC3 || out_valid_o !== 1'b1 || fifo_rd_valid_o !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold got d=%02h v=%0b rd=%0b expected d=c3 v=1 rd=0",
                         out_data_o, out_valid_o, fifo_rd_valid_o);
            end
            if (i == 0) begin @(posedge clk); #1; end
        end
        @(posedge clk); #1;
        out_ready_i = 1;
        checks++;
        if (pop_cyc.size() != npops) begin
            failures++;
            $display("FAIL stall_no_pop pops=%0d expected=%0d", pop_cyc.size(), npops);
        end
        wait_drain(ok);
        checks++;
        if (!ok || acc_cyc.size() != 8) begin
            failures++;
            $display("FAIL stall_drain ok=%0b bytes=%0d expected 1/8", ok, acc_cyc.size());
        end
    endtask

    task automatic test_flush_partial;
        row_t r;
        bit ok;
        bit done_pop;
        int dones;
        @(posedge clk); #1;
        last_seen = 0;
        partial = 1;
        out_ready_i = 1;
        @(posedge clk); #1;
        flush_req_i = 1;
        @(posedge clk); #1;
        flush_req_i = 0;
        @(negedge clk);
        checks++;
        if (fifo_flush_o !== 1'b1 || flush_busy_o !== 1'b1) begin
            failures++;
            $display("FAIL flush_rise got fl=%0b busy=%0b expected 1/1", fifo_flush_o, flush_busy_o);
        end
        @(posedge clk); #1;
        r.d = 32'hCCCCCDBA; r.done = 1;
        rows.push_back(r);
        partial = 0;
        done_pop = 0;
        dones = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (flush_done_o) dones++;
            if (done_pop) begin
                done_pop = 0;
                checks++;
                if (fifo_flush_o !== 1'b0 || flush_busy_o !== 1'b1) begin
                    failures++;
                    $display("FAIL flush_fall got fl=%0b busy=%0b expected 0/1", fifo_flush_o, flush_busy_o);
                end
            end
            if (fifo_rd_valid_o && fifo_flush_done_i) done_pop = 1;
        end
        checks++;
        if (dones != 1) begin failures++; $display("FAIL flush_done_pulses got=%0d expected=1", dones); end
        checks++;
        if (last_seen != 1) begin failures++; $display("FAIL flush_last_count got=%0d expected=1", last_seen); end
        wait_drain(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL flush_drain timeout"); end
    endtask

    task automatic test_flush_empty;
        @(posedge clk); #1;
        flush_req_i = 1;
        @(posedge clk); #1;
        flush_req_i = 0;
        @(negedge clk);
        checks++;
        if (flush_done_o !== 1'b1 || fifo_flush_o !== 1'b0 || flush_busy_o !== 1'b0) begin
            failures++;
            $display("FAIL empty_flush got dn=%0b fl=%0b busy=%0b expected 1/0/0",
                     flush_done_o, fifo_flush_o, flush_busy_o);
        end
        @(negedge clk);
        checks++;
        if (flush_done_o !== 1'b0 || fifo_flush_o !== 1'b0 || flush_busy_o !== 1'b0) begin
            failures++;
            $display("FAIL empty_flush_after got dn=%0b fl=%0b busy=%0b expected 0/0/0",
                     flush_done_o, fifo_flush_o, flush_busy_o);
        end
    endtask

    task automatic test_reset_in_drain;
        row_t r;
        bit got;
        @(posedge clk); #1;
        partial = 1;
        out_ready_i = 0;
        @(posedge clk); #1;
        flush_req_i = 1;
        @(posedge clk); #1;
        flush_req_i = 0;
        r.d = 32'h5A5A5A5A; r.done = 1;
        rows.push_back(r);
        partial = 0;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (fifo_rd_valid_o) begin got = 1; break; end
        end
        @(negedge clk);
        checks++;
        if (!got || out_valid_o !== 1'b1 || flush_busy_o !== 1'b1 || fifo_flush_o !== 1'b0) begin
            failures++;
            $display("FAIL drain_entry got pop=%0b v=%0b busy=%0b fl=%0b expected 1/1/1/0",
                     got, out_valid_o, flush_busy_o, fifo_flush_o);
        end
        @(posedge clk); #1;
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        sb.delete();
        @(negedge clk);
        checks++;
        if (out_valid_o !== 1'b0 || flush_busy_o !== 1'b0 || flush_done_o !== 1'b0) begin
            failures++;
            $display("FAIL drain_reset got v=%0b busy=%0b dn=%0b expected 0/0/0",
                     out_valid_o, flush_busy_o, flush_done_o);
        end
        @(negedge clk);
        checks++;
        if (flush_done_o !== 1'b0) begin
            failures++;
            $display("FAIL drain_reset_done got=%0b expected=0", flush_done_o);
        end
        out_ready_i = 1;
    endtask

    initial begin
        reset = 1;
        fifo_data_avail_i = 0;
        fifo_rd_data_i = 32'h0;
        fifo_empty_i = 1;
        fifo_flush_done_i = 0;
        flush_req_i = 0;
        out_ready_i = 0;
        test_reset();
        test_back_to_back();
        test_stall();
        test_flush_partial();
        test_flush_empty();
        test_reset_in_drain();
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover got=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
